tap_replayer: RTL and testbench

- Inverse of the tap counter: takes a 7-bit count and plays it back as that many discrete pulses on one output, e.g. to blink an LED N times.
- Sits downstream of the tap counter.
- A start strobe (typically a debounced key tap) loads the current count value.
- Pulse high/low widths are parameterised, so the same block serves board-speed blinking (12 MHz clock) and fast simulation.

---
 rtl/tap_replayer_pkg.sv | 16 +
 rtl/tap_replayer_if.sv | 22 ++
 rtl/tap_replayer_cycle_timer.sv | 30 +++
 rtl/tap_replayer.sv | 123 ++++++++++++
 tb/tb_tap_replayer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tap_replayer_pkg.sv
// Shared types and board-level defaults for the tap replayer.
package tap_replayer_pkg;

    localparam int CNT_W_DEF       = 7;
    // 0.5 s per phase at a 12 MHz board clock
    localparam int HIGH_CYCLES_DEF = 6000000;
    localparam int LOW_CYCLES_DEF  = 6000000;
    localparam int TIMER_W_DEF     = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/tap_replayer_if.sv
// Control and status bundle between a replay requester and the replayer.
interface tap_replayer_if #(
    parameter int CNT_W = 7
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] count;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, abort, count,
        input  pulse_out, busy, done, remaining
    );

    modport slave (
        input  start, abort, count,
        output pulse_out, busy, done, remaining
    );
endinterface

// File: rtl/tap_replayer_cycle_timer.sv
// Phase timer shared by the HIGH and LOW phases of the replayer.
module tap_replayer_cycle_timer #(
    parameter int HIGH_CYCLES = 6000000,
    parameter int LOW_CYCLES  = 6000000,
    parameter int TIMER_W     = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sel_low,
    output logic tc
);
    localparam logic [TIMER_W-1:0] HIGH_LAST = TIMER_W'(HIGH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOW_LAST  = TIMER_W'(LOW_CYCLES - 1);

    logic [TIMER_W-1:0] tmr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
        end else if (clear) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + TIMER_W'(1);
        end
    end

    assign tc = sel_low ? (tmr_q == LOW_LAST) : (tmr_q == HIGH_LAST);

endmodule

// File: rtl/tap_replayer.sv
// Replays a latched count as a train of fixed-width pulses on pulse_out.
module tap_replayer
    import tap_replayer_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HIGH_CYCLES = HIGH_CYCLES_DEF,
    parameter int LOW_CYCLES  = LOW_CYCLES_DEF,
    parameter int TIMER_W     = TIMER_W_DEF
) (
    input logic           clk,
    input logic           rst,
    tap_replayer_if.slave bus
);
    state_t           state_q, state_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             tmr_clr;
    logic             tmr_sel_low;
    logic             tmr_tc;

    tap_replayer_cycle_timer #(
        .HIGH_CYCLES (HIGH_CYCLES),
        .LOW_CYCLES  (LOW_CYCLES),
        .TIMER_W     (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clr),
        .sel_low (tmr_sel_low),
        .tc      (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
        end
    end

    // The timer is held clear in IDLE and on every state change.
    always_comb begin
        state_d     = state_q;
        pulse_d     = pulse_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rem_d       = rem_q;
        tmr_clr     = 1'b1;
        tmr_sel_low = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.count != '0) begin
                        state_d = HIGH;
                        pulse_d = 1'b1;
                        busy_d  = 1'b1;
                        rem_d   = bus.count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                tmr_clr = 1'b0;
                if (bus.abort) begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    rem_d   = '0;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    state_d = LOW;
                    pulse_d = 1'b0;
                    tmr_clr = 1'b1;
                end
            end
            LOW: begin
                tmr_clr     = 1'b0;
                tmr_sel_low = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    rem_d   = '0;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    rem_d   = rem_q - CNT_W'(1);
                    tmr_clr = 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = HIGH;
                        pulse_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                rem_d   = '0;
            end
        endcase
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = rem_q;

endmodule

// File: tb/tb_tap_replayer.sv
// Directed bench for tap_replayer with 3-cycle highs and 2-cycle lows.
module tb_tap_replayer;

    localparam int CW = 7;
    localparam int HC = 3;
    localparam int LC = 2;
    localparam int PER = HC + LC;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tap_replayer_if #(.CNT_W(CW)) bus ();

    tap_replayer #(
        .CNT_W       (CW),
        .HIGH_CYCLES (HC),
        .LOW_CYCLES  (LC),
        .TIMER_W     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a playback and gathers statistics over a fixed window.
    task automatic measure(
        input  int cnt,
        input  int budget,
        input  int inj_at,
        input  int inj_cnt,
        output int busy_n,
        output int rise_n,
        output int done_n,
        output int max_rem,
        output int last_busy,
        output int first_done
    );
        logic prev;
        prev       = 1'b0;
        busy_n     = 0;
        rise_n     = 0;
        done_n     = 0;
        max_rem    = 0;
        last_busy  = -1;
        first_done = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = CW'(cnt);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_n++;
                last_busy = k;
            end
            if (bus.pulse_out && !prev) rise_n++;
            prev = bus.pulse_out;
            if (bus.done) begin
                done_n++;
                if (first_done < 0) first_done = k;
            end
            if (int'(bus.remaining) > max_rem) max_rem = int'(bus.remaining);
            bus.start = (k == inj_at);
            if (k == inj_at) bus.count = CW'(inj_cnt);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.count = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000 ||
            bus.remaining !== 7'd0) begin
            errors++;
            $display("FAIL reset: p=%b b=%b d=%b r=%0d expected all 0",
                     bus.pulse_out, bus.busy, bus.done, bus.remaining);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic exp_p;
        int   exp_r;
        int   bad;
        bad = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = 7'd3;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k <= 15) begin
                exp_p = ((k - 1) % PER) < HC;
                exp_r = 3 - (k - 1) / PER;
                checks++;
                if (bus.pulse_out !== exp_p || bus.busy !== 1'b1 ||
                    bus.done !== 1'b0 || int'(bus.remaining) != exp_r) begin
                    errors++;
                    $display("FAIL basic cyc%0d: p=%b b=%b d=%b r=%0d want p=%b b=1 d=0 r=%0d",
                             k, bus.pulse_out, bus.busy, bus.done,
                             bus.remaining, exp_p, exp_r);
                end
            end else begin
                checks++;
                if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0 ||
                    bus.remaining !== 7'd0 || bus.done !== (k == 16)) begin
                    errors++;
                    $display("FAIL basic end cyc%0d: p=%b b=%b d=%b r=%0d want d=%b others 0",
                             k, bus.pulse_out, bus.busy, bus.done,
                             bus.remaining, (k == 16));
                end
            end
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = 7'd0;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pulse_out !== 1'b0) begin
            errors++;
            $display("FAIL zero: d=%b b=%b p=%b want d=1 b=0 p=0",
                     bus.done, bus.busy, bus.pulse_out);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pulse_out !== 1'b0) begin
                errors++;
                $display("FAIL zero after: d=%b b=%b p=%b want all 0",
                         bus.done, bus.busy, bus.pulse_out);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int bn, rn, dn, mr, lb, fd;
        measure(2, 14, 7, 5, bn, rn, dn, mr, lb, fd);
        checks++;
        if (rn != 2 || bn != 2 * PER || dn != 1 || mr != 2) begin
            errors++;
            $display("FAIL busy_start: pulses=%0d busy=%0d done=%0d maxrem=%0d want 2 %0d 1 2",
                     rn, bn, dn, mr, 2 * PER);
        end
        checks++;
        if (fd != lb + 1) begin
            errors++;
            $display("FAIL busy_start done_edge: done at %0d busy last %0d",
                     fd, lb);
        end
    endtask

    task automatic test_abort();
        int bn, rn, dn, mr, lb, fd;
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = 7'd4;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.pulse_out !== 1'b1 || bus.remaining !== 7'd3) begin
            errors++;
            $display("FAIL abort pre: p=%b r=%0d want p=1 r=3",
                     bus.pulse_out, bus.remaining);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0 ||
            bus.remaining !== 7'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort: p=%b b=%b r=%0d d=%b want all 0",
                     bus.pulse_out, bus.busy, bus.remaining, bus.done);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.pulse_out) seen_done = 1;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort quiet: activity=%0d want 0", seen_done);
        end
        measure(1, 8, -1, 0, bn, rn, dn, mr, lb, fd);
        checks++;
        if (rn != 1 || bn != PER || dn != 1 || mr != 1) begin
            errors++;
            $display("FAIL abort restart: pulses=%0d busy=%0d done=%0d maxrem=%0d want 1 %0d 1 1",
                     rn, bn, dn, mr, PER);
        end
    endtask

    task automatic test_start_abort();
        int act;
        act = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.count = 7'd6;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.busy || bus.pulse_out || bus.done || bus.remaining != 0)
                act = 1;
            @(negedge clk);
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL start_abort: activity=%0d want 0", act);
        end
    endtask

    task automatic test_long_and_reset();
        int bn, rn, dn, mr, lb, fd;
        measure(127, 127 * PER + 5, -1, 0, bn, rn, dn, mr, lb, fd);
        checks++;
        if (rn != 127 || bn != 127 * PER || dn != 1 || mr != 127) begin
            errors++;
            $display("FAIL long: pulses=%0d busy=%0d done=%0d maxrem=%0d want 127 %0d 1 127",
                     rn, bn, dn, mr, 127 * PER);
        end
        checks++;
        if (fd != lb + 1) begin
            errors++;
            $display("FAIL long done_edge: done at %0d busy last %0d", fd, lb);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = 7'd127;
        repeat (51) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.pulse_out !== 1'b1 || bus.remaining !== 7'd117) begin
            errors++;
            $display("FAIL long mid: b=%b p=%b r=%0d want b=1 p=1 r=117",
                     bus.busy, bus.pulse_out, bus.remaining);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000 ||
            bus.remaining !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: p=%b b=%b d=%b r=%0d want all 0",
                     bus.pulse_out, bus.busy, bus.done, bus.remaining);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.pulse_out !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset idle: b=%b p=%b d=%b want 0",
                     bus.busy, bus.pulse_out, bus.done);
        end
        bus.start = 1'b1;
        bus.count = 7'd2;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.pulse_out !== 1'b1 || bus.remaining !== 7'd2) begin
            errors++;
            $display("FAIL post_reset start: b=%b p=%b r=%0d want 1 1 2",
                     bus.busy, bus.pulse_out, bus.remaining);
        end
        repeat (2 * PER + 2) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_zero();
        test_start_while_busy();
        test_abort();
        test_start_abort();
        test_long_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
